// File: rtl/max_pool_pkg.sv
// Shared definitions for the max-pool datapath: user sideband bit positions
// and a ceil(log2) helper for sizing counters.
package max_pool_pkg;

    localparam int USER_LAST_COL = 0;
    localparam int USER_LAST_ROW = 1;
    localparam int USER_LAST_CHN = 2;

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Fully registered AXI-Stream slice (forward + backward) with a one-entry skid
// buffer. Only built when MAX_POOL_PACKER_OUT_REG_EN is defined.
`ifdef MAX_POOL_PACKER_OUT_REG_EN
module axis_reg_slice #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    logic [DATA_W-1:0] out_p1;
    logic [DATA_W-1:0] skid_p1;
    logic              vld_p1;
    logic              skid_vld_p1;

    // Ready only depends on skid occupancy, which breaks the m_ready path.
    assign s_ready = ~skid_vld_p1;
    assign m_data  = out_p1;
    assign m_valid = vld_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_p1      <= '0;
            skid_p1     <= '0;
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (m_ready || !vld_p1) begin
            if (skid_vld_p1) begin
                out_p1      <= skid_p1;
                vld_p1      <= 1'b1;
                skid_vld_p1 <= 1'b0;
            end else begin
                vld_p1 <= s_valid;
                if (s_valid) begin
                    out_p1 <= s_data;
                end
            end
        end else if (s_valid && !skid_vld_p1) begin
            skid_p1     <= s_data;
            skid_vld_p1 <= 1'b1;
        end
    end

endmodule
`endif

// File: rtl/max_pool_item_packer.sv
// Repacks low-aligned max-pool item groups into dense N-item beats and flushes
// the packet tail as one partial beat. MAX_POOL_PACKER_OUT_REG_EN adds an output slice.
module max_pool_item_packer
    import max_pool_pkg::*;
#(
    parameter int feature_n_per_clk  = 4,
    parameter int feature_data_width = 8
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [(feature_n_per_clk+1)*feature_data_width-1:0] s_axis_data,
    input  logic [(feature_n_per_clk+1)*feature_data_width/8-1:0] s_axis_keep,
    input  logic [2:0]                                          s_axis_user,
    input  logic                                                s_axis_last,
    input  logic                                                s_axis_valid,
    output logic                                                s_axis_ready,
    output logic [feature_n_per_clk*feature_data_width-1:0]     m_axis_data,
    output logic [feature_n_per_clk*feature_data_width/8-1:0]   m_axis_keep,
    output logic [2:0]                                          m_axis_user,
    output logic                                                m_axis_last,
    output logic                                                m_axis_valid,
    input  logic                                                m_axis_ready
);

    localparam int N     = feature_n_per_clk;
    localparam int W     = feature_data_width;
    localparam int KB    = W / 8;
    localparam int CNT_W = clogb2(2 * N) + 1;
    localparam logic [CNT_W-1:0] CNT_N  = CNT_W'(N);
    localparam logic [CNT_W-1:0] CNT_2N = CNT_W'(2 * N);

    logic [2*N*W-1:0] buf_p1, buf_shift, buf_nxt;
    logic [CNT_W-1:0] cnt_p1, cnt_shift, cnt_nxt, k_in, out_items;
    logic             flushing_p1, flushing_nxt;
    logic             flush_empty_p1, flush_empty_nxt;
    logic [2:0]       user_p1;
    logic             core_valid, core_ready, core_last;
    logic             out_fire, in_fire;
    logic [N*KB-1:0]  core_keep;
    logic [N*W-1:0]   core_data;
    logic             unused_keep;

    // Only the first byte enable of each item is meaningful.
    assign unused_keep = ^s_axis_keep;

    always_comb begin : item_count
        logic run;
        k_in = '0;
        run  = 1'b1;
        for (int i = 0; i <= N; i++) begin
            if (run && s_axis_keep[i*KB]) begin
                k_in = k_in + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    assign out_items  = (cnt_p1 >= CNT_N) ? CNT_N : cnt_p1;
    assign core_valid = (cnt_p1 >= CNT_N) | (flushing_p1 & (cnt_p1 != '0)) | flush_empty_p1;
    assign core_last  = flushing_p1 & (cnt_p1 <= CNT_N);
    assign core_data  = buf_p1[N*W-1:0];
    assign out_fire   = core_valid & core_ready;

    always_comb begin
        core_keep = '0;
        for (int i = 0; i < N; i++) begin
            core_keep[i*KB +: KB] = (CNT_W'(i) < out_items) ? {KB{1'b1}} : {KB{1'b0}};
        end
    end

    // A full buffer cannot take input even while draining: cnt < 2N gates it.
    assign s_axis_ready = ~rst & ~flushing_p1 &
                          ((cnt_p1 < CNT_N) | (out_fire & (cnt_p1 < CNT_2N)));
    assign in_fire      = s_axis_valid & s_axis_ready;

    always_comb begin
        cnt_shift = out_fire ? (cnt_p1 - out_items) : cnt_p1;
        buf_shift = out_fire ? (buf_p1 >> (N * W)) : buf_p1;
        buf_nxt   = buf_shift;
        if (in_fire) begin
            for (int j = 0; j < 2 * N; j++) begin
                for (int i = 0; i <= N; i++) begin
                    if ((CNT_W'(i) < k_in) && ((cnt_shift + CNT_W'(i)) == CNT_W'(j))) begin
                        buf_nxt[j*W +: W] = s_axis_data[i*W +: W];
                    end
                end
            end
        end
        cnt_nxt         = cnt_shift + (in_fire ? k_in : '0);
        flushing_nxt    = flushing_p1;
        flush_empty_nxt = flush_empty_p1;
        if (out_fire && core_last) begin
            flushing_nxt    = 1'b0;
            flush_empty_nxt = 1'b0;
        end
        if (in_fire && s_axis_last) begin
            flushing_nxt = 1'b1;
            if (cnt_nxt == '0) begin
                flush_empty_nxt = 1'b1;
            end
        end
    end

    // ---- stage p1: item buffer and packet state ----
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_p1         <= '0;
            cnt_p1         <= '0;
            flushing_p1    <= 1'b0;
            flush_empty_p1 <= 1'b0;
            user_p1        <= '0;
        end else begin
            buf_p1         <= buf_nxt;
            cnt_p1         <= cnt_nxt;
            flushing_p1    <= flushing_nxt;
            flush_empty_p1 <= flush_empty_nxt;
            if (in_fire) begin
                user_p1 <= s_axis_user;
            end
        end
    end

`ifdef MAX_POOL_PACKER_OUT_REG_EN
    localparam int PAY_W = N * W + N * KB + 3 + 1;

    logic [PAY_W-1:0] slice_in, slice_out;

    // ---- stage p2: registered output slice ----
    assign slice_in = {core_data, core_keep, user_p1, core_last};

    axis_reg_slice #(
        .DATA_W(PAY_W)
    ) u_out_slice (
        .clk     (clk),
        .rst     (rst),
        .s_data  (slice_in),
        .s_valid (core_valid),
        .s_ready (core_ready),
        .m_data  (slice_out),
        .m_valid (m_axis_valid),
        .m_ready (m_axis_ready)
    );

    assign {m_axis_data, m_axis_keep, m_axis_user, m_axis_last} = slice_out;
`else
    assign core_ready   = m_axis_ready;
    assign m_axis_data  = core_data;
    assign m_axis_keep  = core_keep;
    assign m_axis_user  = user_p1;
    assign m_axis_last  = core_last;
    assign m_axis_valid = core_valid;
`endif

endmodule

// File: tb/tb_max_pool_item_packer.sv
// Scoreboard bench for max_pool_item_packer: expected beats are derived from the
// accepted item stream per packet and checked by an independent output monitor.
module tb_max_pool_item_packer;
    import max_pool_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int KB = W / 8;
`ifdef MAX_POOL_PACKER_OUT_REG_EN
    localparam int STALL_GROUPS = 3;
`else
    localparam int STALL_GROUPS = 1;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [(N+1)*W-1:0]     s_data;
    logic [(N+1)*KB-1:0]    s_keep;
    logic [2:0]             s_user;
    logic                   s_last, s_valid, s_ready;
    logic [N*W-1:0]         m_data;
    logic [N*KB-1:0]        m_keep;
    logic [2:0]             m_user;
    logic                   m_last, m_valid, m_ready;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [N*W-1:0] data;
        int             cnt;
        bit             last;
        logic [2:0]     user;
    } beat_t;

    beat_t          exp_q[$];
    logic [W-1:0]   pend[$];
    beat_t          mon_b;

    max_pool_item_packer #(
        .feature_n_per_clk  (N),
        .feature_data_width (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_data  (s_data),
        .s_axis_keep  (s_keep),
        .s_axis_user  (s_user),
        .s_axis_last  (s_last),
        .s_axis_valid (s_valid),
        .s_axis_ready (s_ready),
        .m_axis_data  (m_data),
        .m_axis_keep  (m_keep),
        .m_axis_user  (m_user),
        .m_axis_last  (m_last),
        .m_axis_valid (m_valid),
        .m_axis_ready (m_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_chunk(input int n, input bit last, input logic [2:0] user);
        beat_t b;
        b.data = '0;
        for (int i = 0; i < n; i++) b.data[i*W +: W] = pend.pop_front();
        b.cnt  = n;
        b.last = last;
        b.user = user;
        exp_q.push_back(b);
    endtask

    // Reference: items form one ordered stream per packet; full beats leave as
    // soon as N are known not to be the tail, and the tail leaves as the last beat.
    task automatic model_accept();
        int k;
        k = 0;
        for (int i = 0; i <= N; i++) begin
            if (s_keep[i*KB]) k++;
            else break;
        end
        for (int i = 0; i < k; i++) pend.push_back(s_data[i*W +: W]);
        if (!s_last) begin
            while (pend.size() >= N) push_chunk(N, 1'b0, 3'b000);
        end else begin
            while (pend.size() > N) push_chunk(N, 1'b0, 3'b000);
            push_chunk(pend.size(), 1'b1, s_user);
        end
    endtask

    task automatic tick(output bit acc);
        #1;
        acc = s_valid && s_ready && !rst;
        if (acc) model_accept();
        @(negedge clk);
    endtask

    task automatic set_beat(input logic [N:0] iv, input bit last, input logic [2:0] user);
        for (int i = 0; i <= N; i++) begin
            s_keep[i*KB +: KB] = {KB{iv[i]}};
            s_data[i*W +: W]   = W'($urandom);
        end
        s_last  = last;
        s_user  = user;
        s_valid = 1'b1;
    endtask

    task automatic send(input logic [N:0] iv, input bit last, input logic [2:0] user);
        bit acc;
        acc = 1'b0;
        set_beat(iv, last, user);
        for (int t = 0; t < 200 && !acc; t++) tick(acc);
        check("send_accepted", acc, 1);
        s_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) tick(acc);
        check("drain_complete", exp_q.size(), 0);
        repeat (3) tick(acc);
    endtask

    // Output monitor: every handshaked beat is popped and compared.
    always @(negedge clk) begin
        logic [N*W-1:0]  mask;
        logic [N*KB-1:0] kreq;
        #3;
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual keep=%0h last=%0b required no beat at %0t",
                         m_keep, m_last, $time);
            end else begin
                mon_b = exp_q.pop_front();
                mask  = '0;
                kreq  = '0;
                for (int i = 0; i < mon_b.cnt; i++) begin
                    mask[i*W +: W]  = '1;
                    kreq[i*KB +: KB] = '1;
                end
                check("beat_keep", m_keep, kreq);
                check("beat_last", m_last, mon_b.last);
                check("beat_data", m_data & mask, mon_b.data);
                if (mon_b.last) check("beat_user", m_user, mon_b.user);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit         acc;
        logic [2:0] u;
        logic [N*W-1:0]  hold_d;
        logic [N*KB-1:0] hold_k;
        logic [N:0] iv;

        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        s_data = '0; s_keep = '0; s_user = '0; s_last = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last",  m_last,  0);
        check("rst_m_keep",  m_keep,  0);
        check("rst_m_data",  m_data,  0);
        check("rst_m_user",  m_user,  0);
        check("rst_s_ready", s_ready, 0);
        rst = 1'b0;
        #1;
        check("ready_after_release", s_ready, 1);
        @(negedge clk);

        // Two 3-item groups then a 1-item tail with user {chn,col}.
        m_ready = 1'b1;
        send(5'b00111, 1'b0, 3'b000);
        send(5'b00111, 1'b0, 3'b000);
        u = '0;
        u[USER_LAST_CHN] = 1'b1;
        u[USER_LAST_COL] = 1'b1;
        send(5'b00001, 1'b1, u);
        #1;
        check("ready_during_flush", s_ready, 0);
        drain();

        // Back-to-back full groups exercise the cnt=2N stall.
        for (int g = 0; g < 4; g++) send(5'b11111, 1'b0, 3'b010);
        send(5'b00000, 1'b1, 3'b110);
        drain();

        // Output back-pressure: payload holds and input stalls.
        m_ready = 1'b0;
        for (int g = 0; g < STALL_GROUPS; g++) send(5'b01111, 1'b0, 3'b000);
        repeat (3) tick(acc);
        #1;
        check("stall_m_valid", m_valid, 1);
        hold_d = m_data;
        hold_k = m_keep;
        for (int c = 0; c < 5; c++) begin
            tick(acc);
            #1;
            check("stall_s_ready", s_ready, 0);
            check("stall_data",    m_data, hold_d);
            check("stall_keep",    m_keep, hold_k);
        end
        m_ready = 1'b1;
        send(5'b00000, 1'b1, 3'b001);
        drain();

        // Empty last group on an empty buffer.
        send(5'b00000, 1'b1, 3'b100);
        drain();
        #1;
        check("ready_after_empty_flush", s_ready, 1);
        @(negedge clk);

        // Reset in the middle of a flush discards it.
        m_ready = 1'b0;
        send(5'b00111, 1'b1, 3'b011);
        tick(acc);
        rst = 1'b1;
        exp_q.delete();
        pend.delete();
        tick(acc);
        #1;
        check("rst_flush_m_valid", m_valid, 0);
        check("rst_flush_m_keep",  m_keep,  0);
        rst = 1'b0;
        #1;
        check("rst_flush_s_ready", s_ready, 1);
        @(negedge clk);
        m_ready = 1'b1;
        send(5'b00011, 1'b1, 3'b111);
        drain();

        // Randomized traffic with random back-pressure.
        for (int c = 0; c < 400; c++) begin
            if (!s_valid && ($urandom % 10) < 7) begin
                if ($urandom % 2) begin
                    iv = (N+1)'((1 << $urandom_range(0, N + 1)) - 1);
                end else begin
                    iv = (N+1)'($urandom);
                end
                set_beat(iv, ($urandom % 6) == 0, 3'($urandom));
            end
            m_ready = ($urandom % 10) < 7;
            tick(acc);
            if (acc) s_valid = 1'b0;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        send(5'b00000, 1'b1, 3'b010);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
